cfeb_sync_seq: RTL and testbench

Sequencer that re-establishes CFEB fiber frame alignment after a TTC resync or a detected loss of sync. It walks the 7 CFEB links (0-3 ME1b, 4-6 ME1a) one at a time. For each link it requests a realign, waits for link_good plus a frame-marker (FC K-char) strobe, and bounds every wait with a timeout and retry budget. It drives the per-link cfeb_sync_done vector consumed by the CSC sync monitor and reports failures to the VME status logic.

---
 rtl/cfeb_sync_seq.sv | 215 +++++++++++++++++++++
 tb/tb_cfeb_sync_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfeb_sync_seq.sv
// cfeb_sync_seq: walks the CFEB fiber links one at a time after a TTC resync
// (or an automatic lost-sync restart), requesting a realign on each enabled
// link and waiting for link_good together with an FC frame-marker strobe.
// Every wait is bounded by a timeout and a per-link retry budget.
//
// Ports:
//   clock, global_reset_n         40 MHz clock, async active-low reset
//   ttc_resync                    resync request, rising edge starts a sequence
//   auto_resync_en                allow lost-sync flags to restart from IDLE
//   cfebs_lostsync, cfebs_me1a_lostsync  sticky lost-sync flags (ME1b / ME1a)
//   cfeb_fiber_enable[MXCFEB]     per-link enable; disabled links are marked done
//   link_good[MXCFEB]             per-link receiver lock
//   fc_marker[MXCFEB]             per-link frame-marker strobe
//   realign_req[MXCFEB]           one-hot single-clock realign pulse
//   cfeb_sync_done[MXCFEB]        per-link alignment complete
//   sync_fail[MXCFEB]             sticky per-link failure (retries exhausted)
//   seq_busy                      sequence in progress
//   seq_state[3]                  current state code for readback
//   retry_cnt[2]                  attempts used on the current link
module cfeb_sync_seq #(
    parameter int unsigned MXCFEB  = 7,
    parameter int unsigned TMRBITS = 10,
    parameter int unsigned TIMEOUT = 600,
    parameter int unsigned MXRETRY = 3,
    parameter int unsigned SETTLE  = 8
) (
    input  logic              clock,
    input  logic              global_reset_n,
    input  logic              ttc_resync,
    input  logic              auto_resync_en,
    input  logic              cfebs_lostsync,
    input  logic              cfebs_me1a_lostsync,
    input  logic [MXCFEB-1:0] cfeb_fiber_enable,
    input  logic [MXCFEB-1:0] link_good,
    input  logic [MXCFEB-1:0] fc_marker,
    output logic [MXCFEB-1:0] realign_req,
    output logic [MXCFEB-1:0] cfeb_sync_done,
    output logic [MXCFEB-1:0] sync_fail,
    output logic              seq_busy,
    output logic [2:0]        seq_state,
    output logic [1:0]        retry_cnt
);

    localparam int unsigned IDXW = $clog2(MXCFEB + 1);
    localparam int unsigned RTYW = 2;

    // Elaboration-time sanity on the counter widths.
    if ((TIMEOUT >= (32'd1 << TMRBITS)) || (SETTLE >= (32'd1 << TMRBITS))) begin : g_tmr_chk
        $error("cfeb_sync_seq: TMRBITS too narrow for TIMEOUT/SETTLE");
    end
    if ((MXRETRY == 0) || (MXRETRY >= (32'd1 << RTYW))) begin : g_rty_chk
        $error("cfeb_sync_seq: MXRETRY must be 1..3");
    end
    if ((TIMEOUT == 0) || (SETTLE == 0)) begin : g_zero_chk
        $error("cfeb_sync_seq: TIMEOUT and SETTLE must be non-zero");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SELECT = 3'd2,
        ST_REQ    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_WAIT   = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic                 ttc_q, ttc_d;
    logic                 ran_q, ran_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [TMRBITS-1:0]   tmr_q, tmr_d;
    logic [RTYW-1:0]      retry_q, retry_d;
    logic [MXCFEB-1:0]    req_q, req_d;
    logic [MXCFEB-1:0]    done_q, done_d;
    logic [MXCFEB-1:0]    fail_q, fail_d;
    logic                 busy_q, busy_d;

    logic                 trig_ttc_c;
    logic                 trig_lost_c;
    logic                 hit_c;

    // Rising edge of the resync input; abort-and-restart from any state.
    assign trig_ttc_c  = ttc_resync & ~ttc_q;

    // Lost-sync restart only from IDLE after a finished sequence, never while busy,
    // since the monitor keeps lostsync high until every done bit is set.
    assign trig_lost_c = auto_resync_en & (cfebs_lostsync | cfebs_me1a_lostsync) &
                         ran_q & ~busy_q & (state_q == ST_IDLE);

    assign hit_c = link_good[idx_q] & fc_marker[idx_q];

    // Next-state and output computation.
    always_comb begin
        state_d = state_q;
        ttc_d   = ttc_resync;
        ran_d   = ran_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        done_d  = done_q;
        fail_d  = fail_q;

        if (trig_ttc_c || trig_lost_c) begin
            state_d = ST_START;
            ran_d   = 1'b0;
            idx_d   = '0;
            tmr_d   = '0;
            retry_d = '0;
            done_d  = '0;
            fail_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A link that loses lock after alignment is no longer done.
                    done_d = done_q & link_good;
                end
                ST_START: begin
                    state_d = ST_SELECT;
                end
                ST_SELECT: begin
                    if (idx_q == IDXW'(MXCFEB)) begin
                        state_d = ST_DONE;
                    end else if (!cfeb_fiber_enable[idx_q]) begin
                        done_d[idx_q] = 1'b1;
                        idx_d         = idx_q + IDXW'(1);
                    end else begin
                        retry_d = '0;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    tmr_d   = TMRBITS'(SETTLE);
                    state_d = ST_SETTLE;
                    if (retry_q != RTYW'(MXRETRY)) begin
                        retry_d = retry_q + RTYW'(1);
                    end
                end
                ST_SETTLE: begin
                    // Markers are ignored here while the receiver re-locks.
                    if (tmr_q <= TMRBITS'(1)) begin
                        tmr_d   = TMRBITS'(TIMEOUT);
                        state_d = ST_WAIT;
                    end else begin
                        tmr_d = tmr_q - TMRBITS'(1);
                    end
                end
                ST_WAIT: begin
                    // Success takes priority over an expiring timer.
                    if (hit_c) begin
                        done_d[idx_q] = 1'b1;
                        idx_d         = idx_q + IDXW'(1);
                        state_d       = ST_SELECT;
                    end else if (tmr_q <= TMRBITS'(1)) begin
                        if (retry_q < RTYW'(MXRETRY)) begin
                            state_d = ST_REQ;
                        end else begin
                            fail_d[idx_q] = 1'b1;
                            idx_d         = idx_q + IDXW'(1);
                            state_d       = ST_SELECT;
                        end
                    end else begin
                        tmr_d = tmr_q - TMRBITS'(1);
                    end
                end
                ST_DONE: begin
                    ran_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered outputs follow the next state so they line up with seq_state.
        req_d  = (state_d == ST_REQ) ? (MXCFEB'(1) << idx_d) : '0;
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q <= ST_IDLE;
            ttc_q   <= 1'b0;
            ran_q   <= 1'b0;
            idx_q   <= '0;
            tmr_q   <= '0;
            retry_q <= '0;
            req_q   <= '0;
            done_q  <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ttc_q   <= ttc_d;
            ran_q   <= ran_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
        end
    end

    assign realign_req    = req_q;
    assign cfeb_sync_done = done_q;
    assign sync_fail      = fail_q;
    assign seq_busy       = busy_q;
    assign seq_state      = state_q;
    assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_cfeb_sync_seq.sv
// Testbench for cfeb_sync_seq: emulates the link receivers (realign -> delayed
// frame marker) and predicts the realign pulse timeline, retry counts and the
// final done/fail vectors from the sequencing rules using plain arithmetic.
`timescale 1ns/1ps
module tb_cfeb_sync_seq;

    localparam int NL        = 7;
    localparam int SETTLE_C  = 8;
    localparam int TIMEOUT_C = 600;
    localparam int PERIOD    = SETTLE_C + TIMEOUT_C + 1;

    logic          clock = 1'b0;
    logic          global_reset_n;
    logic          ttc_resync;
    logic          auto_resync_en;
    logic          cfebs_lostsync;
    logic          cfebs_me1a_lostsync;
    logic [NL-1:0] cfeb_fiber_enable;
    logic [NL-1:0] link_good;
    logic [NL-1:0] fc_marker;
    logic [NL-1:0] realign_req;
    logic [NL-1:0] cfeb_sync_done;
    logic [NL-1:0] sync_fail;
    logic          seq_busy;
    logic [2:0]    seq_state;
    logic [1:0]    retry_cnt;

    cfeb_sync_seq dut (
        .clock               (clock),
        .global_reset_n      (global_reset_n),
        .ttc_resync          (ttc_resync),
        .auto_resync_en      (auto_resync_en),
        .cfebs_lostsync      (cfebs_lostsync),
        .cfebs_me1a_lostsync (cfebs_me1a_lostsync),
        .cfeb_fiber_enable   (cfeb_fiber_enable),
        .link_good           (link_good),
        .fc_marker           (fc_marker),
        .realign_req         (realign_req),
        .cfeb_sync_done      (cfeb_sync_done),
        .sync_fail           (sync_fail),
        .seq_busy            (seq_busy),
        .seq_state           (seq_state),
        .retry_cnt           (retry_cnt)
    );

    always #12 clock = ~clock;

    typedef struct {
        int s;
        int l;
        int a;
    } pulse_t;

    int            checks   = 0;
    int            failures = 0;
    int            slot     = 0;

    // Per-link, per-attempt responder behaviour (dly 0 = no marker).
    logic [NL-1:0] en;
    logic [NL-1:0] base_good;
    int            dly   [NL][3];
    int            early [NL][3];
    bit            glow  [NL][3];

    int            mk_slot [NL];
    int            ea_slot [NL];
    bit            mk_low  [NL];
    int            att     [NL];

    pulse_t        expq[$];
    logic [NL-1:0] edone;
    logic [NL-1:0] efail;
    int            idle_slot;
    int            rchk_slot;
    int            rchk_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h slot=%0d", tag, got, exp, slot);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        slot++;
    endtask

    task automatic cfg_clear(input int d);
        for (int i = 0; i < NL; i++) begin
            for (int a = 0; a < 3; a++) begin
                dly[i][a]   = (a == 0) ? d : 0;
                early[i][a] = 0;
                glow[i][a]  = 1'b0;
            end
        end
    endtask

    task automatic clear_resp();
        for (int i = 0; i < NL; i++) begin
            mk_slot[i] = -1;
            ea_slot[i] = -1;
            mk_low[i]  = 1'b0;
            att[i]     = 0;
        end
        rchk_slot = -1;
    endtask

    task automatic drive_resp();
        for (int i = 0; i < NL; i++) begin
            fc_marker[i] = (slot == mk_slot[i]) || (slot == ea_slot[i]);
            link_good[i] = base_good[i] & ~((slot == mk_slot[i]) & mk_low[i]);
        end
    endtask

    // Timeline prediction: trigger driven at slot t, START visible at t+1,
    // first link examined at t+2; an attempt is won by a good marker that lands
    // 9..608 slots after its realign pulse, otherwise the next pulse is PERIOD later.
    task automatic build_model(input int t);
        int     s;
        int     p;
        bit     ok;
        pulse_t pe;
        expq.delete();
        edone = '0;
        efail = '0;
        s = t + 2;
        for (int i = 0; i < NL; i++) begin
            if (!en[i]) begin
                edone[i] = 1'b1;
                s = s + 1;
            end else begin
                p  = s + 1;
                ok = 1'b0;
                for (int a = 0; a < 3; a++) begin
                    if (!ok) begin
                        pe.s = p; pe.l = i; pe.a = a + 1;
                        expq.push_back(pe);
                        if (dly[i][a] != 0 && !glow[i][a]) begin
                            ok = 1'b1;
                            s  = p + dly[i][a] + 1;
                        end else begin
                            p = p + PERIOD;
                        end
                    end
                end
                if (ok) edone[i] = 1'b1;
                else begin
                    efail[i] = 1'b1;
                    s = p;
                end
            end
        end
        idle_slot = s + 2;
    endtask

    task automatic monitor();
        int     lk;
        int     a;
        pulse_t pe;
        if (realign_req != '0) begin
            chk("req_onehot", 32'($countones(realign_req)), 32'd1);
            lk = 0;
            for (int i = NL - 1; i >= 0; i--) if (realign_req[i]) lk = i;
            if (expq.size() == 0) begin
                chk("req_unexpected", 32'(realign_req), 32'd0);
            end else begin
                pe = expq.pop_front();
                chk("req_slot", slot, pe.s);
                chk("req_link", lk, pe.l);
                rchk_slot = slot + 1;
                rchk_exp  = pe.a;
            end
            a = att[lk];
            att[lk]++;
            if (a < 3) begin
                mk_slot[lk] = (dly[lk][a] != 0) ? slot + dly[lk][a] : -1;
                ea_slot[lk] = (early[lk][a] != 0) ? slot + early[lk][a] : -1;
                mk_low[lk]  = glow[lk][a];
            end
        end
        if (slot == rchk_slot) chk("retry_cnt", 32'(retry_cnt), rchk_exp);
    endtask

    // mode 0: ttc_resync edge, mode 1: auto lost-sync. abort_link >= 0 fires a
    // second resync 15 slots after that link's first realign pulse.
    task automatic run_seq(input int mode, input int abort_link);
        int t;
        int abort_slot;
        int ttc_hold;
        bit lost_hold;
        int alink;
        alink      = abort_link;
        abort_slot = -1;
        ttc_hold   = 0;
        lost_hold  = 1'b0;
        cfeb_fiber_enable = en;
        t = slot;
        clear_resp();
        build_model(t);
        if (mode == 0) begin
            ttc_resync = 1'b1;
            ttc_hold   = 3;
        end else begin
            auto_resync_en = 1'b1;
            cfebs_lostsync = 1'b1;
            lost_hold      = 1'b1;
        end
        drive_resp();
        tick();
        chk("start_state", 32'(seq_state), 32'd1);
        chk("start_busy", 32'(seq_busy), 32'd1);
        chk("start_done", 32'(cfeb_sync_done), 32'd0);
        chk("start_fail", 32'(sync_fail), 32'd0);
        while (slot < idle_slot + 3) begin
            monitor();
            if (alink >= 0 && abort_slot < 0 && realign_req[alink]) abort_slot = slot + 15;
            if (slot == idle_slot) begin
                chk("end_state", 32'(seq_state), 32'd0);
                chk("end_busy", 32'(seq_busy), 32'd0);
                chk("end_done", 32'(cfeb_sync_done), 32'(edone));
                chk("end_fail", 32'(sync_fail), 32'(efail));
                chk("end_pending", 32'(expq.size()), 32'd0);
            end
            if (slot > idle_slot) chk("idle_hold", 32'(seq_state), 32'd0);
            if (lost_hold && cfeb_sync_done == 7'h7F) begin
                cfebs_lostsync = 1'b0;
                lost_hold      = 1'b0;
            end
            if (ttc_hold > 0) begin
                ttc_hold--;
                if (ttc_hold == 0) ttc_resync = 1'b0;
            end
            if (slot == abort_slot) begin
                chk("abort_in_wait", 32'(seq_state), 32'd5);
                t = slot;
                clear_resp();
                build_model(t);
                ttc_resync = 1'b1;
                ttc_hold   = 3;
                abort_slot = -1;
                alink      = -1;
                drive_resp();
                tick();
                chk("abort_state", 32'(seq_state), 32'd1);
                chk("abort_done", 32'(cfeb_sync_done), 32'd0);
                chk("abort_req", 32'(realign_req), 32'd0);
            end else begin
                drive_resp();
                tick();
            end
        end
        if (lost_hold) begin
            chk("lostsync_release", 32'(cfeb_sync_done), 32'h7F);
            cfebs_lostsync = 1'b0;
        end
    endtask

    initial begin
        global_reset_n      = 1'b0;
        ttc_resync          = 1'b0;
        auto_resync_en      = 1'b0;
        cfebs_lostsync      = 1'b0;
        cfebs_me1a_lostsync = 1'b0;
        base_good           = '1;
        en                  = '1;
        cfeb_fiber_enable   = '1;
        link_good           = '1;
        fc_marker           = '0;
        clear_resp();
        cfg_clear(20);

        repeat (3) tick();
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_req", 32'(realign_req), 32'd0);
        chk("rst_done", 32'(cfeb_sync_done), 32'd0);
        chk("rst_fail", 32'(sync_fail), 32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        global_reset_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(seq_state), 32'd0);

        // Lost-sync before any completed sequence must not start one.
        auto_resync_en = 1'b1;
        cfebs_lostsync = 1'b1;
        repeat (5) tick();
        chk("lost_no_prior_seq", 32'(seq_state), 32'd0);
        cfebs_lostsync = 1'b0;
        auto_resync_en = 1'b0;
        tick();

        // All links, marker 20 clocks after each realign.
        en = 7'h7F; cfg_clear(20);
        run_seq(0, -1);

        // ME1a fibers disabled.
        en = 7'h0F; cfg_clear(20);
        run_seq(0, -1);
        chk("me1b_only_done", 32'(cfeb_sync_done), 32'h7F);

        // Link 2 silent: three attempts then failure, sequence moves on.
        en = 7'h7F; cfg_clear(20);
        dly[2][0] = 0;
        run_seq(0, -1);
        chk("silent_fail", 32'(sync_fail), 32'h04);
        chk("silent_done", 32'(cfeb_sync_done), 32'h7B);

        // Settle-window strobe ignored, WAIT-window boundaries, link_good gating.
        en = 7'h7F; cfg_clear(20);
        dly[0][0] = TIMEOUT_C + SETTLE_C;
        early[1][0] = 4; dly[1][0] = 30;
        dly[3][0] = SETTLE_C + 1;
        early[4][0] = SETTLE_C;
        dly[5][0] = 25; glow[5][0] = 1'b1; dly[5][1] = 12;
        run_seq(0, -1);

        // Resync while link 4 is in WAIT: abort and restart from link 0.
        en = 7'h7F; cfg_clear(20);
        run_seq(0, 4);

        // Automatic restart on lost-sync, no retrigger while busy.
        en = 7'h7F; cfg_clear(20);
        run_seq(1, -1);
        repeat (4) begin
            tick();
            chk("auto_idle", 32'(seq_state), 32'd0);
        end
        auto_resync_en      = 1'b0;
        cfebs_me1a_lostsync = 1'b1;
        repeat (6) tick();
        chk("auto_off_idle", 32'(seq_state), 32'd0);
        cfebs_me1a_lostsync = 1'b0;

        // Link losing lock while idle clears only its done bit.
        base_good[3] = 1'b0;
        drive_resp();
        tick();
        chk("idle_drop_done", 32'(cfeb_sync_done), 32'h77);
        base_good[3] = 1'b1;
        drive_resp();
        repeat (3) tick();
        chk("idle_drop_hold", 32'(cfeb_sync_done), 32'h77);
        chk("idle_drop_state", 32'(seq_state), 32'd0);

        // Randomized link behaviour.
        for (int r = 0; r < 5; r++) begin
            en = NL'($urandom) | 7'h01;
            for (int i = 0; i < NL; i++) begin
                for (int a = 0; a < 3; a++) begin
                    dly[i][a]   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(SETTLE_C + 1, 60));
                    early[i][a] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SETTLE_C)) : 0;
                    glow[i][a]  = ($urandom_range(0, 7) == 0);
                end
            end
            run_seq(0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
